// File: rtl/dmx_pkg.sv
// dmx_pkg: shared DMX512 transmitter types, constants and baud divider helper
package dmx_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_BREAK, ST_MAB, ST_SLOT, ST_DONE} dmx_state_e;
  localparam int DMX_SLOT_BITS = 11;
  localparam int DMX_MAX_SLOTS = 512;
  function automatic int dmx_div(input int clock_hz, input int baud_hz);
    return (clock_hz + baud_hz / 2) / baud_hz;
  endfunction
endpackage

// File: rtl/dmx_baud_tick.sv
// dmx_baud_tick: one-cycle clock enable every round(CLOCK_HZ/BAUD_HZ) cycles
module dmx_baud_tick
  import dmx_pkg::*;
#(
  parameter int CLOCK_HZ = 12000000,
  parameter int BAUD_HZ  = 250000
) (
  input  logic clock,
  input  logic reset,
  input  logic restart,
  output logic tick
);
  localparam int DIV = dmx_div(CLOCK_HZ, BAUD_HZ);
  localparam int CW  = DIV > 1 ? $clog2(DIV) : 1;
  logic [CW-1:0] cnt;
  assign tick = cnt == CW'(DIV - 1);
  always_ff @(posedge clock or posedge reset)
    if (reset) cnt <= '0;
    else cnt <= (restart || tick) ? '0 : cnt + CW'(1);
endmodule

// File: rtl/dmx_tx.sv
// dmx_tx: DMX512 frame transmitter (break, MAB, start code, buffered data slots)
module dmx_tx
  import dmx_pkg::*;
#(
  parameter int CLOCK_HZ   = 12000000,
  parameter int BAUD_HZ    = 250000,
  parameter int NUM_SLOTS  = 512,
  parameter int BREAK_BITS = 23,
  parameter int MAB_BITS   = 3,
  localparam int AW = NUM_SLOTS > 1 ? $clog2(NUM_SLOTS) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          enable,
  input  logic [7:0]    start_code,
  input  logic [9:0]    slot_count,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  output logic          tx,
  output logic          tx_en,
  output logic          busy,
  output logic          frame_done
);
  dmx_state_e state, nxt;
  logic tick, bit_end;
  logic [7:0] bit_cnt, lim, sh, start_q, rd_data;
  logic [9:0] slot_idx, n_slots, cnt_eff;
  logic [AW-1:0] rd_addr;
  logic [7:0] mem [NUM_SLOTS];

  dmx_baud_tick #(.CLOCK_HZ(CLOCK_HZ), .BAUD_HZ(BAUD_HZ)) u_tick (
    .clock(clock),
    .reset(reset),
    .restart(state == ST_IDLE || state == ST_DONE),
    .tick(tick)
  );

  assign lim = state == ST_BREAK ? 8'(BREAK_BITS - 1) :
               state == ST_MAB   ? 8'(MAB_BITS - 1)   : 8'(DMX_SLOT_BITS - 1);
  assign bit_end = tick && bit_cnt == lim;
  assign cnt_eff = (slot_count == '0 || 32'(slot_count) > NUM_SLOTS) ? 10'(NUM_SLOTS) : slot_count;
  // During slot k the RAM fetches the byte for slot k+1, ready at that slot's start bit
  assign rd_addr = 32'(slot_idx) < NUM_SLOTS ? slot_idx[AW-1:0] : '0;

  always_ff @(posedge clock or posedge reset)
    if (reset) state <= ST_IDLE;
    else state <= nxt;

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:  nxt = enable ? ST_BREAK : ST_IDLE;
      ST_BREAK: nxt = bit_end ? ST_MAB : ST_BREAK;
      ST_MAB:   nxt = bit_end ? ST_SLOT : ST_MAB;
      ST_SLOT:  nxt = (bit_end && slot_idx == n_slots) ? ST_DONE : ST_SLOT;
      ST_DONE:  nxt = enable ? ST_BREAK : ST_IDLE;
      default:  nxt = ST_IDLE;
    endcase
  end

  assign tx = state == ST_BREAK ? 1'b0 :
              state != ST_SLOT  ? 1'b1 :
              bit_cnt == 8'd0   ? 1'b0 :
              bit_cnt <= 8'd8   ? sh[0] : 1'b1;
  assign tx_en      = 1'b1;
  assign busy       = state != ST_IDLE;
  assign frame_done = state == ST_DONE;

  // The slot byte is captured into sh at slot start, so later buffer writes cannot disturb it
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      bit_cnt  <= '0;
      slot_idx <= '0;
      n_slots  <= '0;
      start_q  <= '0;
      sh       <= '0;
    end else if (nxt == ST_BREAK && state != ST_BREAK) begin
      bit_cnt  <= '0;
      slot_idx <= '0;
      n_slots  <= cnt_eff;
      start_q  <= start_code;
    end else if (tick) begin
      bit_cnt <= bit_end ? '0 : bit_cnt + 8'd1;
      if (bit_end && state == ST_MAB) sh <= start_q;
      else if (bit_end && state == ST_SLOT) begin
        sh       <= rd_data;
        slot_idx <= slot_idx + 10'd1;
      end else if (state == ST_SLOT && bit_cnt != 8'd0 && bit_cnt <= 8'd8) sh <= sh >> 1;
    end

  always_ff @(posedge clock) begin
    if (wr_en && 32'(wr_addr) < NUM_SLOTS) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end
endmodule

// File: tb/tb_dmx_tx.sv
// tb_dmx_tx: directed self-checking bench for dmx_tx at a 4-cycle bit period
module tb_dmx_tx;
  localparam int DIV   = 4;
  localparam int BRK   = 23 * DIV;
  localparam int MABC  = 3 * DIV;
  localparam int SLOTC = 11 * DIV;

  logic clock = 0, reset = 1, enable = 0, wr_en = 0;
  logic [7:0] start_code = 0, wr_data = 0;
  logic [9:0] slot_count = 0;
  logic [8:0] wr_addr = 0;
  logic tx, tx_en, busy, frame_done;
  int total = 0, bad = 0;
  logic [7:0] exp_b [0:512];

  always #5 clock = ~clock;

  dmx_tx #(.CLOCK_HZ(1000000), .BAUD_HZ(250000), .NUM_SLOTS(512), .BREAK_BITS(23), .MAB_BITS(3)) dut (
    .clock(clock), .reset(reset), .enable(enable), .start_code(start_code), .slot_count(slot_count),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .tx(tx), .tx_en(tx_en), .busy(busy), .frame_done(frame_done)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input int a, input logic [7:0] d);
    wr_en = 1; wr_addr = 9'(a); wr_data = d;
    step();
    wr_en = 0;
  endtask

  function automatic logic exp_tx(input int t, input int n);
    int s, b;
    if (t < BRK) return 1'b0;
    if (t < BRK + MABC) return 1'b1;
    s = (t - BRK - MABC) / SLOTC;
    b = ((t - BRK - MABC) % SLOTC) / DIV;
    if (s > n) return 1'b1;
    if (b == 0) return 1'b0;
    if (b <= 8) return exp_b[s][b-1];
    return 1'b1;
  endfunction

  // Called at break cycle 0; checks the whole frame and returns at the cycle after DONE
  task automatic run_frame(input string name, input int n, input int w1t, input int w1a, input logic [7:0] w1d,
                           input int w2t, input int w2a, input logic [7:0] w2d);
    int len, txe, fde, bse, first;
    len = BRK + MABC + (n + 1) * SLOTC + 1;
    txe = 0; fde = 0; bse = 0; first = -1;
    for (int t = 0; t < len; t++) begin
      if (tx !== exp_tx(t, n)) begin
        txe++;
        if (first < 0) first = t;
      end
      if (frame_done !== (t == len - 1)) fde++;
      if (busy !== 1'b1 || tx_en !== 1'b1) bse++;
      if (t == w1t) begin wr_en = 1; wr_addr = 9'(w1a); wr_data = w1d; end
      else if (t == w2t) begin wr_en = 1; wr_addr = 9'(w2a); wr_data = w2d; end
      else wr_en = 0;
      step();
    end
    wr_en = 0;
    total += 3;
    if (txe != 0) begin bad++; $display("FAIL %s tx wave: %0d wrong cycles, first at %0d, expected 0 wrong", name, txe, first); end
    if (fde != 0) begin bad++; $display("FAIL %s frame_done: %0d wrong cycles, expected single pulse at %0d", name, fde, len - 1); end
    if (bse != 0) begin bad++; $display("FAIL %s busy/tx_en: %0d cycles not high, expected 0", name, bse); end
  endtask

  task automatic chk_idle(input string name);
    total++;
    if (busy !== 1'b0 || tx !== 1'b1) begin bad++; $display("FAIL %s idle: busy=%b tx=%b, expected busy=0 tx=1", name, busy, tx); end
  endtask

  task automatic test_reset();
    #1;
    total += 4;
    if (tx !== 1'b1) begin bad++; $display("FAIL reset tx: got %b want 1", tx); end
    if (tx_en !== 1'b1) begin bad++; $display("FAIL reset tx_en: got %b want 1", tx_en); end
    if (busy !== 1'b0) begin bad++; $display("FAIL reset busy: got %b want 0", busy); end
    if (frame_done !== 1'b0) begin bad++; $display("FAIL reset frame_done: got %b want 0", frame_done); end
    repeat (3) step();
    reset = 0;
    repeat (20) step();
    chk_idle("no_enable");
  endtask

  task automatic test_frame();
    wr(0, 8'h55); wr(1, 8'hAA); wr(2, 8'h0F);
    exp_b[0] = 8'h00; exp_b[1] = 8'h55; exp_b[2] = 8'hAA; exp_b[3] = 8'h0F;
    start_code = 8'h00; slot_count = 10'd3; enable = 1;
    step();
    start_code = 8'hC3; slot_count = 10'd2;
    run_frame("frame3", 3, -1, 0, 8'h00, -1, 0, 8'h00);
  endtask

  task automatic test_back_to_back();
    total++;
    if (tx !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL b2b_break: tx=%b busy=%b, expected tx=0 busy=1", tx, busy); end
    exp_b[0] = 8'hC3;
    enable = 0;
    run_frame("b2b", 2, -1, 0, 8'h00, -1, 0, 8'h00);
    chk_idle("b2b_end");
  endtask

  task automatic test_pulse();
    int extra;
    start_code = 8'h3C; slot_count = 10'd1; enable = 1;
    step();
    enable = 0;
    exp_b[0] = 8'h3C;
    run_frame("pulse", 1, -1, 0, 8'h00, -1, 0, 8'h00);
    chk_idle("pulse_end");
    extra = 0;
    for (int i = 0; i < 300; i++) begin
      if (busy !== 1'b0 || frame_done !== 1'b0) extra++;
      step();
    end
    total++;
    if (extra != 0) begin bad++; $display("FAIL pulse_single: %0d active cycles after frame, expected 0", extra); end
  endtask

  task automatic test_midframe_write();
    start_code = 8'h00; slot_count = 10'd3; enable = 1;
    step();
    enable = 0;
    exp_b[0] = 8'h00; exp_b[1] = 8'h55; exp_b[2] = 8'hAA; exp_b[3] = 8'hFF;
    run_frame("midwr", 3, BRK + MABC + SLOTC + 2, 2, 8'hFF, BRK + MABC + SLOTC + 22, 0, 8'h11);
    enable = 1;
    step();
    enable = 0;
    exp_b[1] = 8'h11;
    run_frame("midwr_next", 3, -1, 0, 8'h00, -1, 0, 8'h00);
    chk_idle("midwr_end");
  endtask

  task automatic test_clamp();
    for (int a = 0; a < 512; a++) wr(a, 8'(a * 7 + 3));
    exp_b[0] = 8'h5A;
    for (int k = 1; k <= 512; k++) exp_b[k] = 8'((k - 1) * 7 + 3);
    start_code = 8'h5A; slot_count = 10'd0; enable = 1;
    step();
    enable = 0; slot_count = 10'd600;
    run_frame("clamp0", 512, -1, 0, 8'h00, -1, 0, 8'h00);
    chk_idle("clamp0_end");
    enable = 1;
    step();
    enable = 0;
    run_frame("clamp600", 512, -1, 0, 8'h00, -1, 0, 8'h00);
    chk_idle("clamp600_end");
  endtask

  task automatic test_reset_midframe();
    start_code = 8'h00; slot_count = 10'd2; enable = 1;
    step();
    repeat (130) step();
    total++;
    if (tx !== 1'b0) begin bad++; $display("FAIL pre_reset_tx: got %b want 0", tx); end
    #2 reset = 1;
    #1;
    total += 2;
    if (tx !== 1'b1) begin bad++; $display("FAIL async_reset_tx: got %b want 1", tx); end
    if (busy !== 1'b0) begin bad++; $display("FAIL async_reset_busy: got %b want 0", busy); end
    #1 reset = 0;
    step();
    enable = 0;
    exp_b[0] = 8'h00; exp_b[1] = 8'h03; exp_b[2] = 8'h0A;
    run_frame("after_reset", 2, -1, 0, 8'h00, -1, 0, 8'h00);
    chk_idle("after_reset_end");
  endtask

  initial begin
    test_reset();
    test_frame();
    test_back_to_back();
    test_pulse();
    test_midframe_write();
    test_clamp();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
